bka_chunk_scheduler: RTL and testbench



---
 rtl/bka_chunk_scheduler_pkg.sv | 23 ++
 rtl/bka_chunk_scheduler_if.sv | 32 +++
 rtl/bka_chunk_scheduler_arbiter.sv | 61 ++++++
 rtl/brent_kung_adder.sv | 40 ++++
 rtl/bka_chunk_scheduler.sv | 138 +++++++++++++
 tb/tb_bka_chunk_scheduler.sv | 245 ++++++++++++++++++++++++
 6 files changed

// File: rtl/bka_chunk_scheduler_pkg.sv
// Shared state type, default widths and width helpers for bka_chunk_scheduler.
package bka_sched_pkg;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_OP_WIDTH    = 32;
  localparam int DEF_ADDER_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } bka_sched_state_e;

  function automatic int calc_num_chunks(input int op_width, input int adder_width);
    return op_width / adder_width;
  endfunction

  // Never returns 0 so single-entry counters/indices still get a bit.
  function automatic int calc_id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/bka_chunk_scheduler_if.sv
// Request/response bundle between requesters and bka_chunk_scheduler.
interface bka_chunk_scheduler_if #(
  parameter int NUM_REQ  = bka_sched_pkg::DEF_NUM_REQ,
  parameter int OP_WIDTH = bka_sched_pkg::DEF_OP_WIDTH
);
  import bka_sched_pkg::*;

  localparam int ID_WIDTH = calc_id_width(NUM_REQ);

  logic [NUM_REQ-1:0]               req_valid_i;
  logic [NUM_REQ-1:0]               req_ready_o;
  logic [NUM_REQ-1:0][OP_WIDTH-1:0] req_a_i;
  logic [NUM_REQ-1:0][OP_WIDTH-1:0] req_b_i;
  logic [NUM_REQ-1:0]               req_cin_i;
  logic                             rsp_valid_o;
  logic                             rsp_ready_i;
  logic [OP_WIDTH-1:0]              rsp_sum_o;
  logic                             rsp_cout_o;
  logic [ID_WIDTH-1:0]              rsp_id_o;
  logic                             busy_o;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, req_cin_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_sum_o, rsp_cout_o, rsp_id_o, busy_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, req_cin_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_sum_o, rsp_cout_o, rsp_id_o, busy_o
  );

endinterface

// File: rtl/bka_chunk_scheduler_arbiter.sv
// Requester arbiter: round-robin when BKA_SCHED_RR_EN is defined, otherwise
// fixed priority (lowest index wins, no pointer state).
module bka_rr_arbiter #(
  parameter int NUM_REQ  = bka_sched_pkg::DEF_NUM_REQ,
  parameter int ID_WIDTH = bka_sched_pkg::calc_id_width(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic                i_advance,
  output logic [NUM_REQ-1:0]  o_grant,
  output logic [ID_WIDTH-1:0] o_idx
);

  logic w_found;

`ifdef BKA_SCHED_RR_EN
  logic [ID_WIDTH-1:0] r_last;
  logic                w_hit;
  int                  w_cand;

  // Last-granted pointer; reset so that requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= ID_WIDTH'(NUM_REQ - 1);
    end else if (i_advance) begin
      r_last <= o_idx;
    end
  end

  always_comb begin
    o_idx   = '0;
    w_found = 1'b0;
    w_hit   = 1'b0;
    w_cand  = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_cand  = (int'(r_last) + off) % NUM_REQ;
      w_hit   = !w_found && i_req[w_cand];
      o_idx   = w_hit ? ID_WIDTH'(w_cand) : o_idx;
      w_found = w_found | w_hit;
    end
    o_grant = w_found ? (NUM_REQ'(1'b1) << o_idx) : '0;
  end
`else
  logic w_unused;

  // Scan from the top so the lowest asserted index is the final pick.
  always_comb begin
    o_idx   = '0;
    w_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      o_idx   = i_req[i] ? ID_WIDTH'(i) : o_idx;
      w_found = w_found | i_req[i];
    end
    o_grant = w_found ? (NUM_REQ'(1'b1) << o_idx) : '0;
  end

  assign w_unused = ^{clk, rst, i_advance};
`endif

endmodule

// File: rtl/brent_kung_adder.sv
// Parallel-prefix (Brent-Kung) adder; NO_CARRY=1 ties the carry-out low.
module brent_kung_adder #(
  parameter int WIDTH    = 8,
  parameter bit NO_CARRY = 1'b0
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  localparam int TOP_SPAN = (WIDTH > 1) ? (1 << ($clog2(WIDTH) - 1)) : 1;

  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_gp;
  logic [WIDTH-1:0] w_pp;

  // Up-sweep builds power-of-two group terms, down-sweep fills in the rest.
  always_comb begin
    w_p  = i_a ^ i_b;
    w_gp = i_a & i_b;
    w_pp = w_p;
    for (int d = 1; d < WIDTH; d = d * 2) begin
      for (int i = 2 * d - 1; i < WIDTH; i = i + 2 * d) begin
        w_gp[i] = w_gp[i] | (w_pp[i] & w_gp[i-d]);
        w_pp[i] = w_pp[i] & w_pp[i-d];
      end
    end
    for (int d = TOP_SPAN; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < WIDTH; i = i + 2 * d) begin
        w_gp[i] = w_gp[i] | (w_pp[i] & w_gp[i-d]);
        w_pp[i] = w_pp[i] & w_pp[i-d];
      end
    end
  end

  assign o_sum   = w_p ^ {w_gp[WIDTH-2:0], 1'b0};
  assign o_carry = NO_CARRY ? 1'b0 : w_gp[WIDTH-1];

endmodule

// File: rtl/bka_chunk_scheduler.sv
// Shares one Brent-Kung adder among NUM_REQ requesters, one ADDER_WIDTH chunk
// per cycle. Arbitration policy selected by BKA_SCHED_RR_EN (see bka_rr_arbiter).
module bka_chunk_scheduler #(
  parameter int NUM_REQ     = bka_sched_pkg::DEF_NUM_REQ,
  parameter int OP_WIDTH    = bka_sched_pkg::DEF_OP_WIDTH,
  parameter int ADDER_WIDTH = bka_sched_pkg::DEF_ADDER_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  bka_chunk_scheduler_if.slave bus
);
  import bka_sched_pkg::*;

  localparam int NUM_CHUNKS = calc_num_chunks(OP_WIDTH, ADDER_WIDTH);
  localparam int ID_WIDTH   = calc_id_width(NUM_REQ);
  localparam int CNT_WIDTH  = calc_id_width(NUM_CHUNKS);

  bka_sched_state_e r_state, w_state_nxt;

  logic [OP_WIDTH-1:0]    r_a, r_b, r_acc, r_sum;
  logic                   r_carry, r_cout, r_valid, r_busy;
  logic [ID_WIDTH-1:0]    r_id;
  logic [CNT_WIDTH-1:0]   r_chunk;
  logic [NUM_REQ-1:0]     w_grant, w_ready;
  logic [ID_WIDTH-1:0]    w_grant_idx;
  logic                   w_accept, w_last_chunk;
  logic [ADDER_WIDTH:0]   w_add_sum;
  logic                   w_add_cout, w_unused_lsb;
  logic [OP_WIDTH-1:0]    w_acc_next;

  bka_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (bus.req_valid_i),
    .i_advance (w_accept),
    .o_grant   (w_grant),
    .o_idx     (w_grant_idx)
  );

  // The constant 1 in bit 0 turns the adder's missing carry-in into carry_q.
  brent_kung_adder #(.WIDTH(ADDER_WIDTH + 1), .NO_CARRY(1'b0)) u_adder (
    .i_a     ({r_a[ADDER_WIDTH-1:0], 1'b1}),
    .i_b     ({r_b[ADDER_WIDTH-1:0], r_carry}),
    .o_sum   (w_add_sum),
    .o_carry (w_add_cout)
  );

  assign w_unused_lsb = w_add_sum[0];
  assign w_last_chunk = (r_chunk == CNT_WIDTH'(NUM_CHUNKS - 1));

  // New chunk enters at the top; after NUM_CHUNKS shifts chunk 0 is at the LSB.
  always_comb begin
    w_acc_next = r_acc >> ADDER_WIDTH;
    w_acc_next[OP_WIDTH-1 -: ADDER_WIDTH] = w_add_sum[ADDER_WIDTH:1];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready     = rst ? '0 : w_grant;
        w_accept    = |w_ready;
        w_state_nxt = w_accept ? BUSY : IDLE;
      end
      BUSY:    w_state_nxt = w_last_chunk ? DONE : BUSY;
      DONE:    w_state_nxt = bus.rsp_ready_i ? IDLE : DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_id    <= '0;
      r_chunk <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= bus.req_a_i[w_grant_idx];
            r_b     <= bus.req_b_i[w_grant_idx];
            r_carry <= bus.req_cin_i[w_grant_idx];
            r_id    <= w_grant_idx;
            r_chunk <= '0;
            r_busy  <= 1'b1;
          end
        end
        BUSY: begin
          r_a     <= r_a >> ADDER_WIDTH;
          r_b     <= r_b >> ADDER_WIDTH;
          r_acc   <= w_acc_next;
          r_carry <= w_add_cout;
          r_chunk <= r_chunk + CNT_WIDTH'(1);
          if (w_last_chunk) begin
            r_sum   <= w_acc_next;
            r_cout  <= w_add_cout;
            r_valid <= 1'b1;
          end
        end
        DONE: begin
          if (bus.rsp_ready_i) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready_o = w_ready;
  assign bus.rsp_valid_o = r_valid;
  assign bus.rsp_sum_o   = r_sum;
  assign bus.rsp_cout_o  = r_cout;
  assign bus.rsp_id_o    = r_id;
  assign bus.busy_o      = r_busy;

endmodule

// File: tb/tb_bka_chunk_scheduler.sv
// Directed and random checks for bka_chunk_scheduler (either arbitration build).
module tb_bka_chunk_scheduler;

  localparam int NREQ = 4;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  bka_chunk_scheduler_if #(.NUM_REQ(NREQ), .OP_WIDTH(32)) bus ();

  bka_chunk_scheduler #(.NUM_REQ(NREQ), .OP_WIDTH(32), .ADDER_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no summary, want summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Presents one request at a negedge, checks its grant, returns just after the accept edge.
  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b, input logic cin);
    @(negedge clk);
    chk("no_stale_rsp", 64'(bus.rsp_valid_o), 64'd0);
    bus.req_a_i[id]   = a;
    bus.req_b_i[id]   = b;
    bus.req_cin_i[id] = cin;
    bus.req_valid_i   = 4'b0001 << id;
    #1;
    chk("req_ready_grant", 64'(bus.req_ready_o), 64'(4'b0001 << id));
    @(posedge clk);
    #1;
    bus.req_valid_i = 4'b0000;
  endtask

  // Counts negedges until rsp_valid_o is seen; edges = index of the edge that could take it.
  task automatic wait_rsp(output int edges);
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
    end while (!bus.rsp_valid_o && edges < 50);
    if (!bus.rsp_valid_o) chk("rsp_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    vec_t        vecs [8];
    int          exp_order [5];
    int          edges;
    int          n_rsp;
    int          rid;
    logic [31:0] ra, rb;
    logic        rc;
    logic [32:0] rexp;
    logic        got;
    int          cyc;

    vecs[0] = '{0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0};
    vecs[1] = '{2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[2] = '{1, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
    vecs[3] = '{3, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1};
    vecs[4] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{1, 32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0};
    vecs[6] = '{2, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0};
    vecs[7] = '{3, 32'hDEAD_BEEF, 32'h2152_4110, 1'b0, 32'hFFFF_FFFF, 1'b0};
`ifdef BKA_SCHED_RR_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif

    // Reset with every requester asking: nothing may be granted.
    rst             = 1'b1;
    bus.req_valid_i = 4'b1111;
    bus.req_a_i     = '0;
    bus.req_b_i     = '0;
    bus.req_cin_i   = 4'b0000;
    bus.rsp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("rst_rsp_sum",   64'(bus.rsp_sum_o),   64'd0);
    chk("rst_rsp_cout",  64'(bus.rsp_cout_o),  64'd0);
    chk("rst_rsp_id",    64'(bus.rsp_id_o),    64'd0);
    chk("rst_busy",      64'(bus.busy_o),      64'd0);
    bus.req_valid_i = 4'b0000;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_no_accept", 64'(bus.busy_o), 64'd0);

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_rsp(edges);
      if (i == 0) chk("latency_edges", 64'(edges), 64'd5);
      chk($sformatf("vec%0d_sum", i),  64'(bus.rsp_sum_o),  64'(vecs[i].sum));
      chk($sformatf("vec%0d_cout", i), 64'(bus.rsp_cout_o), 64'(vecs[i].cout));
      chk($sformatf("vec%0d_id", i),   64'(bus.rsp_id_o),   64'(vecs[i].id));
      @(posedge clk);
      #1;
      if (i == 0) begin
        @(negedge clk);
        chk("valid_fall", 64'(bus.rsp_valid_o), 64'd0);
        chk("busy_fall",  64'(bus.busy_o),      64'd0);
      end
    end

    // Fairness: all requesters held valid from a fresh reset.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int r = 0; r < NREQ; r++) begin
      bus.req_a_i[r]   = 32'(r + 1);
      bus.req_b_i[r]   = 32'h0000_0010;
      bus.req_cin_i[r] = 1'b0;
    end
    @(negedge clk);
    bus.req_valid_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(edges);
      chk($sformatf("fair%0d_id", k),  64'(bus.rsp_id_o),  64'(exp_order[k]));
      chk($sformatf("fair%0d_sum", k), 64'(bus.rsp_sum_o), 64'(exp_order[k] + 17));
      if (k > 0) chk($sformatf("fair%0d_gap", k), 64'(edges), 64'd6);
      if (k == 4) bus.req_valid_i = 4'b0000;
    end
    @(posedge clk);
    #1;

    // Backpressure: response held in DONE while another requester waits.
    bus.rsp_ready_i  = 1'b0;
    bus.req_a_i[3]   = 32'h0000_0005;
    bus.req_b_i[3]   = 32'h0000_0006;
    bus.req_cin_i[3] = 1'b0;
    issue(1, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1);
    bus.req_valid_i = 4'b1000;
    wait_rsp(edges);
    chk("bp_sum",  64'(bus.rsp_sum_o),  64'h0);
    chk("bp_cout", 64'(bus.rsp_cout_o), 64'd1);
    chk("bp_id",   64'(bus.rsp_id_o),   64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(bus.rsp_valid_o), 64'd1);
      chk("bp_hold_sum",   64'(bus.rsp_sum_o),   64'h0);
      chk("bp_hold_cout",  64'(bus.rsp_cout_o),  64'd1);
      chk("bp_hold_id",    64'(bus.rsp_id_o),    64'd1);
      chk("bp_hold_ready", 64'(bus.req_ready_o), 64'd0);
      chk("bp_hold_busy",  64'(bus.busy_o),      64'd1);
    end
    bus.rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("bp_release_busy",  64'(bus.busy_o),      64'd0);
    chk("bp_release_idle",  64'(bus.req_ready_o), 64'(4'b1000));
    bus.req_valid_i = 4'b0000;

    // Reset lands on the edge that would process chunk 2.
    bus.req_a_i[1]   = 32'h0000_0010;
    bus.req_b_i[1]   = 32'h0000_0020;
    bus.req_cin_i[1] = 1'b0;
    bus.req_a_i[3]   = 32'h0000_0100;
    bus.req_b_i[3]   = 32'h0000_0200;
    bus.req_cin_i[3] = 1'b1;
    issue(0, 32'hAAAA_0000, 32'h0000_0001, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus.req_valid_i = 4'b1010;
    @(negedge clk);
    chk("midrst_valid", 64'(bus.rsp_valid_o), 64'd0);
    chk("midrst_busy",  64'(bus.busy_o),      64'd0);
    chk("midrst_ready", 64'(bus.req_ready_o), 64'd0);
    rst = 1'b0;
    #1;
    chk("midrst_grant1", 64'(bus.req_ready_o), 64'(4'b0010));
    @(posedge clk);
    #1;
    bus.req_valid_i = 4'b1000;
    wait_rsp(edges);
    chk("midrst_lat",  64'(edges),           64'd5);
    chk("midrst_id1",  64'(bus.rsp_id_o),    64'd1);
    chk("midrst_sum1", 64'(bus.rsp_sum_o),   64'h30);
    wait_rsp(edges);
    chk("midrst_id3",  64'(bus.rsp_id_o),    64'd3);
    chk("midrst_sum3", 64'(bus.rsp_sum_o),   64'h301);
    bus.req_valid_i = 4'b0000;
    @(posedge clk);
    #1;

    // Random operands, random response backpressure, one op in flight.
    n_rsp = 0;
    for (int n = 0; n < 1000; n++) begin
      rid  = int'($urandom_range(0, NREQ - 1));
      ra   = $urandom;
      rb   = $urandom;
      rc   = 1'($urandom_range(0, 1));
      rexp = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      issue(rid, ra, rb, rc);
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < 100) begin
        @(negedge clk);
        cyc++;
        bus.rsp_ready_i = 1'($urandom_range(0, 1));
        if (bus.rsp_valid_o && bus.rsp_ready_i) begin
          got = 1'b1;
          n_rsp++;
          chk($sformatf("rand%0d_rsp", n),
              64'({bus.rsp_id_o, bus.rsp_cout_o, bus.rsp_sum_o}),
              64'({2'(rid), rexp}));
        end
      end
      if (!got) chk($sformatf("rand%0d_timeout", n), 64'd0, 64'd1);
      @(posedge clk);
      #1;
    end
    bus.rsp_ready_i = 1'b1;
    chk("rand_rsp_count", 64'(n_rsp), 64'd1000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
